// File: rtl/vtage_pkg.sv
// VTAGE tagged-bank shared types and helpers.
// Entry layout, index width and saturating counter helpers.
package vtage_pkg;

  localparam int VALUE_W     = 32;
  localparam int CONF_W      = 3;
  localparam int TAG_W       = 8;
  localparam int U_W         = 2;
  localparam int NUM_ENTRIES = 256;
  localparam int IDX_W       = $clog2(NUM_ENTRIES);

  localparam logic [CONF_W-1:0] CONF_MAX = '1;
  localparam logic [U_W-1:0]    U_MAX    = '1;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [VALUE_W-1:0] value;
    logic [CONF_W-1:0]  conf;
    logic [U_W-1:0]     useful;
  } entry_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v >= max) ? max : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(
    input logic [7:0] v
  );
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/vtage_entry_update.sv
// Next-entry computation for one feedback port.
// Covers hit training, allocation and refused allocation.
module vtage_entry_update
  import vtage_pkg::*;
(
  input  entry_t             ent,
  input  logic               fb_valid,
  input  logic [TAG_W-1:0]   fb_tag,
  input  logic [VALUE_W-1:0] fb_actual,
  input  logic               fb_hit,
  input  logic               fb_alloc,
  output entry_t             nxt,
  output logic               we,
  output logic               alloc_fail
);

  logic do_hit;
  logic do_alloc;
  logic do_refuse;
  logic free;

  always_comb begin
    free      = !ent.valid || (ent.useful == '0);
    do_hit    = fb_valid && fb_hit && (ent.tag == fb_tag);
    do_alloc  = fb_valid && !fb_hit && fb_alloc && free;
    do_refuse = fb_valid && !fb_hit && fb_alloc && !free;
  end

  always_comb begin
    nxt        = ent;
    we         = 1'b0;
    alloc_fail = 1'b0;
    unique case (1'b1)
      do_hit: begin
        we = 1'b1;
        if (ent.value == fb_actual) begin
          nxt.conf   = CONF_W'(sat_inc(8'(ent.conf), 8'(CONF_MAX)));
          nxt.useful = U_W'(sat_inc(8'(ent.useful), 8'(U_MAX)));
        end else begin
          nxt.value  = fb_actual;
          nxt.conf   = '0;
          nxt.useful = U_W'(sat_dec(8'(ent.useful)));
        end
      end
      do_alloc: begin
        we         = 1'b1;
        nxt.valid  = 1'b1;
        nxt.tag    = fb_tag;
        nxt.value  = fb_actual;
        nxt.conf   = '0;
        nxt.useful = '0;
      end
      do_refuse: begin
        we         = 1'b1;
        alloc_fail = 1'b1;
        nxt.useful = U_W'(sat_dec(8'(ent.useful)));
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vtage_bank_pipe.sv
// VTAGE tagged bank: registered lookups, feedback training, aging.
// Define VTAGE_BANK_FWD_EN to forward same-cycle feedback to lookups.
module vtage_bank_pipe
  import vtage_pkg::*;
#(
  parameter int P_NUM_PRED    = 2,
  parameter int P_NUM_ENTRIES = NUM_ENTRIES,
  parameter int P_VALUE_WIDTH = VALUE_W,
  parameter int P_CONF_WIDTH  = CONF_W,
  parameter int P_TAG_WIDTH   = TAG_W,
  parameter int P_U_WIDTH     = U_W,
  parameter int P_AGE_PERIOD  = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [P_NUM_PRED-1:0] fw_valid_i,
  input  logic [P_NUM_PRED*$clog2(P_NUM_ENTRIES)-1:0] fw_index_i,
  input  logic [P_NUM_PRED*P_TAG_WIDTH-1:0] fw_tag_i,
  output logic [P_NUM_PRED-1:0] pred_valid_o,
  output logic [P_NUM_PRED-1:0] pred_hit_o,
  output logic [P_NUM_PRED*P_VALUE_WIDTH-1:0] pred_value_o,
  output logic [P_NUM_PRED*P_CONF_WIDTH-1:0] pred_conf_o,
  output logic [P_NUM_PRED-1:0] pred_confident_o,
  output logic [P_NUM_PRED*P_U_WIDTH-1:0] pred_useful_o,
  input  logic [P_NUM_PRED-1:0] fb_valid_i,
  input  logic [P_NUM_PRED*$clog2(P_NUM_ENTRIES)-1:0] fb_index_i,
  input  logic [P_NUM_PRED*P_TAG_WIDTH-1:0] fb_tag_i,
  input  logic [P_NUM_PRED*P_VALUE_WIDTH-1:0] fb_actual_i,
  input  logic [P_NUM_PRED-1:0] fb_hit_i,
  input  logic [P_NUM_PRED-1:0] fb_alloc_i,
  output logic [P_NUM_PRED-1:0] fb_conflict_o,
  output logic [P_NUM_PRED-1:0] fb_alloc_fail_o,
  output logic age_pulse_o
);

  localparam int IW = $clog2(P_NUM_ENTRIES);
  localparam int CW = $clog2(P_AGE_PERIOD + P_NUM_PRED + 1);

  entry_t mem [P_NUM_ENTRIES];
  entry_t fb_ent [P_NUM_PRED];
  entry_t nxt [P_NUM_PRED];
  entry_t lk_ent [P_NUM_PRED];

  logic [IW-1:0] fb_idx [P_NUM_PRED];
  logic [IW-1:0] fw_idx [P_NUM_PRED];

  logic [P_NUM_PRED-1:0] win;
  logic [P_NUM_PRED-1:0] lose;
  logic [P_NUM_PRED-1:0] we;
  logic [P_NUM_PRED-1:0] afail;

  logic [CW-1:0] age_cnt;
  logic [CW-1:0] ev;
  logic [CW-1:0] sum;
  logic          aging;

  // Lowest-numbered port owns an index when feedback ports collide.
  always_comb begin
    win = fb_valid_i;
    for (int p = 0; p < P_NUM_PRED; p++) begin
      fb_idx[p] = fb_index_i[p*IW +: IW];
      fw_idx[p] = fw_index_i[p*IW +: IW];
    end
    for (int p = 1; p < P_NUM_PRED; p++) begin
      for (int q = 0; q < p; q++) begin
        if (fb_valid_i[q] && fb_idx[q] == fb_idx[p]) begin
          win[p] = 1'b0;
        end
      end
    end
    lose = fb_valid_i & ~win;
  end

  for (genvar p = 0; p < P_NUM_PRED; p++) begin : g_upd
    assign fb_ent[p] = mem[fb_idx[p]];
    vtage_entry_update u_upd (
      .ent        (fb_ent[p]),
      .fb_valid   (win[p]),
      .fb_tag     (fb_tag_i[p*P_TAG_WIDTH +: P_TAG_WIDTH]),
      .fb_actual  (fb_actual_i[p*P_VALUE_WIDTH +: P_VALUE_WIDTH]),
      .fb_hit     (fb_hit_i[p]),
      .fb_alloc   (fb_alloc_i[p]),
      .nxt        (nxt[p]),
      .we         (we[p]),
      .alloc_fail (afail[p])
    );
  end

  always_comb begin
    ev = '0;
    for (int p = 0; p < P_NUM_PRED; p++) begin
      ev = ev + CW'(we[p]);
    end
    sum   = age_cnt + ev;
    aging = (sum >= CW'(P_AGE_PERIOD));
  end

  always_comb begin
    for (int p = 0; p < P_NUM_PRED; p++) begin
      lk_ent[p] = mem[fw_idx[p]];
`ifdef VTAGE_BANK_FWD_EN
      for (int q = 0; q < P_NUM_PRED; q++) begin
        if (we[q] && fb_idx[q] == fw_idx[p]) begin
          lk_ent[p] = nxt[q];
        end
      end
`endif
    end
  end

  // Feedback writes land after the halving so they take precedence.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < P_NUM_ENTRIES; i++) begin
        mem[i] <= '0;
      end
      age_cnt <= '0;
    end else begin
      if (aging) begin
        for (int i = 0; i < P_NUM_ENTRIES; i++) begin
          mem[i].useful <= mem[i].useful >> 1;
        end
      end
      for (int p = 0; p < P_NUM_PRED; p++) begin
        if (we[p]) begin
          mem[fb_idx[p]] <= nxt[p];
        end
      end
      age_cnt <= aging ? sum - CW'(P_AGE_PERIOD) : sum;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_o     <= '0;
      pred_hit_o       <= '0;
      pred_value_o     <= '0;
      pred_conf_o      <= '0;
      pred_confident_o <= '0;
      pred_useful_o    <= '0;
      fb_conflict_o    <= '0;
      fb_alloc_fail_o  <= '0;
      age_pulse_o      <= 1'b0;
    end else begin
      pred_valid_o    <= fw_valid_i;
      fb_conflict_o   <= lose;
      fb_alloc_fail_o <= afail;
      age_pulse_o     <= aging;
      for (int p = 0; p < P_NUM_PRED; p++) begin
        if (fw_valid_i[p]) begin
          pred_hit_o[p] <= lk_ent[p].valid &&
            (lk_ent[p].tag == fw_tag_i[p*P_TAG_WIDTH +: P_TAG_WIDTH]);
          pred_value_o[p*P_VALUE_WIDTH +: P_VALUE_WIDTH] <= lk_ent[p].value;
          pred_conf_o[p*P_CONF_WIDTH +: P_CONF_WIDTH] <= lk_ent[p].conf;
          pred_confident_o[p] <= (lk_ent[p].conf == CONF_MAX);
          pred_useful_o[p*P_U_WIDTH +: P_U_WIDTH] <= lk_ent[p].useful;
        end else begin
          pred_hit_o[p] <= 1'b0;
          pred_value_o[p*P_VALUE_WIDTH +: P_VALUE_WIDTH] <= '0;
          pred_conf_o[p*P_CONF_WIDTH +: P_CONF_WIDTH] <= '0;
          pred_confident_o[p] <= 1'b0;
          pred_useful_o[p*P_U_WIDTH +: P_U_WIDTH] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vtage_bank_pipe.sv
// Directed bench for vtage_bank_pipe: default bank plus a
// second bank with a short aging period.
module tb_vtage_bank_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  fw_valid, fb_valid, fb_hit, fb_alloc;
  logic [15:0] fw_index, fw_tag, fb_index, fb_tag;
  logic [63:0] fb_actual;
  logic [1:0]  pred_valid, pred_hit, pred_confident;
  logic [63:0] pred_value;
  logic [5:0]  pred_conf;
  logic [3:0]  pred_useful;
  logic [1:0]  fb_conflict, fb_alloc_fail;
  logic        age_pulse;

  logic [1:0]  a_fw_valid, a_fb_valid, a_fb_hit, a_fb_alloc;
  logic [15:0] a_fw_index, a_fw_tag, a_fb_index, a_fb_tag;
  logic [63:0] a_fb_actual;
  logic [1:0]  a_pred_valid, a_pred_hit, a_pred_confident;
  logic [63:0] a_pred_value;
  logic [5:0]  a_pred_conf;
  logic [3:0]  a_pred_useful;
  logic [1:0]  a_fb_conflict, a_fb_alloc_fail;
  logic        a_age_pulse;

  vtage_bank_pipe dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fw_valid_i(fw_valid), .fw_index_i(fw_index), .fw_tag_i(fw_tag),
    .pred_valid_o(pred_valid), .pred_hit_o(pred_hit),
    .pred_value_o(pred_value), .pred_conf_o(pred_conf),
    .pred_confident_o(pred_confident), .pred_useful_o(pred_useful),
    .fb_valid_i(fb_valid), .fb_index_i(fb_index), .fb_tag_i(fb_tag),
    .fb_actual_i(fb_actual), .fb_hit_i(fb_hit), .fb_alloc_i(fb_alloc),
    .fb_conflict_o(fb_conflict), .fb_alloc_fail_o(fb_alloc_fail),
    .age_pulse_o(age_pulse)
  );

  vtage_bank_pipe #(.P_AGE_PERIOD(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .fw_valid_i(a_fw_valid), .fw_index_i(a_fw_index), .fw_tag_i(a_fw_tag),
    .pred_valid_o(a_pred_valid), .pred_hit_o(a_pred_hit),
    .pred_value_o(a_pred_value), .pred_conf_o(a_pred_conf),
    .pred_confident_o(a_pred_confident), .pred_useful_o(a_pred_useful),
    .fb_valid_i(a_fb_valid), .fb_index_i(a_fb_index), .fb_tag_i(a_fb_tag),
    .fb_actual_i(a_fb_actual), .fb_hit_i(a_fb_hit), .fb_alloc_i(a_fb_alloc),
    .fb_conflict_o(a_fb_conflict), .fb_alloc_fail_o(a_fb_alloc_fail),
    .age_pulse_o(a_age_pulse)
  );

  typedef struct packed {
    logic        fbv;
    logic [7:0]  tag;
    logic [31:0] act;
    logic        hit;
    logic        alloc;
    logic        fail;
    logic [7:0]  lk_tag;
    logic        e_hit;
    logic [31:0] e_val;
    logic [2:0]  e_conf;
    logic [1:0]  e_u;
  } vec_t;

  vec_t vt [16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    fw_valid = '0; fb_valid = '0; fb_hit = '0; fb_alloc = '0;
    a_fw_valid = '0; a_fb_valid = '0; a_fb_hit = '0; a_fb_alloc = '0;
  endtask

  task automatic set_fb(input bit a, input int p, input logic [7:0] idx,
                        input logic [7:0] tag, input logic [31:0] act,
                        input logic hit, input logic alloc);
    if (a) begin
      a_fb_valid[p] = 1'b1; a_fb_index[p*8 +: 8] = idx;
      a_fb_tag[p*8 +: 8] = tag; a_fb_actual[p*32 +: 32] = act;
      a_fb_hit[p] = hit; a_fb_alloc[p] = alloc;
    end else begin
      fb_valid[p] = 1'b1; fb_index[p*8 +: 8] = idx;
      fb_tag[p*8 +: 8] = tag; fb_actual[p*32 +: 32] = act;
      fb_hit[p] = hit; fb_alloc[p] = alloc;
    end
  endtask

  task automatic set_lk(input bit a, input int p, input logic [7:0] idx,
                        input logic [7:0] tag);
    if (a) begin
      a_fw_valid[p] = 1'b1; a_fw_index[p*8 +: 8] = idx;
      a_fw_tag[p*8 +: 8] = tag;
    end else begin
      fw_valid[p] = 1'b1; fw_index[p*8 +: 8] = idx;
      fw_tag[p*8 +: 8] = tag;
    end
  endtask

  task automatic chk_pred(input string nm, input int p, input logic hit,
                          input logic [31:0] val, input logic [2:0] conf,
                          input logic [1:0] u);
    chk({nm, ".valid"}, 32'(pred_valid[p]), 32'd1);
    chk({nm, ".hit"}, 32'(pred_hit[p]), 32'(hit));
    chk({nm, ".value"}, pred_value[p*32 +: 32], val);
    chk({nm, ".conf"}, 32'(pred_conf[p*3 +: 3]), 32'(conf));
    chk({nm, ".confident"}, 32'(pred_confident[p]), 32'(conf == 3'd7));
    chk({nm, ".useful"}, 32'(pred_useful[p*2 +: 2]), 32'(u));
  endtask

  initial begin
    fw_index = '0; fw_tag = '0; fb_index = '0; fb_tag = '0; fb_actual = '0;
    a_fw_index = '0; a_fw_tag = '0; a_fb_index = '0; a_fb_tag = '0;
    a_fb_actual = '0;
    clear_in();

    vt[0] = '{1'b0, 8'h3A, 32'h0, 1'b0, 1'b0, 1'b0,
              8'h3A, 1'b0, 32'h0, 3'd0, 2'd0};
    vt[1] = '{1'b1, 8'h3A, 32'h1234, 1'b0, 1'b1, 1'b0,
              8'h3A, 1'b1, 32'h1234, 3'd0, 2'd0};
    for (int k = 1; k <= 7; k++) begin
      vt[k+1] = '{1'b1, 8'h3A, 32'h1234, 1'b1, 1'b0, 1'b0,
                  8'h3A, 1'b1, 32'h1234, 3'(k),
                  (k >= 3) ? 2'd3 : 2'(k)};
    end
    vt[9]  = '{1'b1, 8'h3A, 32'h9999, 1'b1, 1'b0, 1'b0,
               8'h3A, 1'b1, 32'h9999, 3'd0, 2'd2};
    vt[10] = '{1'b1, 8'h11, 32'h5555, 1'b0, 1'b1, 1'b1,
               8'h3A, 1'b1, 32'h9999, 3'd0, 2'd1};
    vt[11] = '{1'b1, 8'h11, 32'h5555, 1'b0, 1'b1, 1'b1,
               8'h3A, 1'b1, 32'h9999, 3'd0, 2'd0};
    vt[12] = '{1'b1, 8'h11, 32'h5555, 1'b0, 1'b1, 1'b0,
               8'h11, 1'b1, 32'h5555, 3'd0, 2'd0};
    vt[13] = '{1'b1, 8'h3A, 32'h7777, 1'b1, 1'b0, 1'b0,
               8'h11, 1'b1, 32'h5555, 3'd0, 2'd0};
    vt[14] = '{1'b0, 8'h3A, 32'h0, 1'b0, 1'b0, 1'b0,
               8'h3A, 1'b0, 32'h5555, 3'd0, 2'd0};
    vt[15] = '{1'b1, 8'h11, 32'h5555, 1'b1, 1'b1, 1'b0,
               8'h11, 1'b1, 32'h5555, 3'd1, 2'd1};

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("rst.pred_valid", 32'(pred_valid), 32'd0);
    chk("rst.conflict", 32'(fb_conflict), 32'd0);
    chk("rst.age", 32'(age_pulse), 32'd0);
    chk("rst.a_age", 32'(a_age_pulse), 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].fbv) begin
        set_fb(0, 0, 8'd5, vt[i].tag, vt[i].act, vt[i].hit, vt[i].alloc);
      end
      step();
      clear_in();
      chk($sformatf("v%0d.alloc_fail", i), 32'(fb_alloc_fail[0]),
          32'(vt[i].fail));
      set_lk(0, 0, 8'd5, vt[i].lk_tag);
      step();
      clear_in();
      chk_pred($sformatf("v%0d", i), 0, vt[i].e_hit, vt[i].e_val,
               vt[i].e_conf, vt[i].e_u);
    end

    step();
    chk("idle.pred_valid", 32'(pred_valid), 32'd0);
    chk("idle.value", pred_value[31:0], 32'd0);

    // Two ports hitting one index: port 0 wins.
    set_fb(0, 0, 8'd9, 8'h22, 32'd100, 1'b0, 1'b1);
    step();
    clear_in();
    set_fb(0, 0, 8'd9, 8'h22, 32'd100, 1'b1, 1'b0);
    set_fb(0, 1, 8'd9, 8'h22, 32'd200, 1'b1, 1'b0);
    step();
    clear_in();
    chk("cfl.conflict", 32'(fb_conflict), 32'h2);
    chk("cfl.alloc_fail", 32'(fb_alloc_fail), 32'h0);
    set_lk(0, 1, 8'd9, 8'h22);
    step();
    clear_in();
    chk("cfl.pulse_end", 32'(fb_conflict), 32'h0);
    chk_pred("cfl.p1", 1, 1'b1, 32'd100, 3'd1, 2'd1);
    chk("cfl.p0_idle", 32'(pred_valid[0]), 32'd0);

    // Lookup and feedback to the same index in one cycle.
    set_fb(0, 0, 8'd12, 8'h33, 32'hAAAA, 1'b0, 1'b1);
    step();
    clear_in();
    set_fb(0, 0, 8'd12, 8'h33, 32'hBBBB, 1'b1, 1'b0);
    set_lk(0, 0, 8'd12, 8'h33);
    step();
    clear_in();
`ifdef VTAGE_BANK_FWD_EN
    chk_pred("rbw.same", 0, 1'b1, 32'hBBBB, 3'd0, 2'd0);
`else
    chk_pred("rbw.same", 0, 1'b1, 32'hAAAA, 3'd0, 2'd0);
`endif
    set_lk(0, 0, 8'd12, 8'h33);
    step();
    clear_in();
    chk_pred("rbw.after", 0, 1'b1, 32'hBBBB, 3'd0, 2'd0);

    // Aging bank: period 4, counter wraps to the excess.
    set_fb(1, 0, 8'd3, 8'h03, 32'd3, 1'b0, 1'b1);
    step(); clear_in(); chk("age.c1", 32'(a_age_pulse), 32'd0);
    for (int c = 2; c <= 3; c++) begin
      set_fb(1, 0, 8'd3, 8'h03, 32'd3, 1'b1, 1'b0);
      step(); clear_in();
      chk($sformatf("age.c%0d", c), 32'(a_age_pulse), 32'd0);
    end
    set_fb(1, 0, 8'd3, 8'h03, 32'd3, 1'b1, 1'b0);
    set_fb(1, 1, 8'd1, 8'h01, 32'd1, 1'b0, 1'b1);
    step(); clear_in(); chk("age.c4", 32'(a_age_pulse), 32'd1);
    set_fb(1, 0, 8'd1, 8'h01, 32'd1, 1'b1, 1'b0);
    set_fb(1, 1, 8'd2, 8'h02, 32'd2, 1'b0, 1'b1);
    step(); clear_in(); chk("age.c5", 32'(a_age_pulse), 32'd0);
    set_fb(1, 0, 8'd1, 8'h01, 32'd1, 1'b1, 1'b0);
    set_fb(1, 1, 8'd2, 8'h02, 32'd2, 1'b1, 1'b0);
    step(); clear_in(); chk("age.c6", 32'(a_age_pulse), 32'd1);
    set_fb(1, 0, 8'd1, 8'h01, 32'd1, 1'b1, 1'b0);
    set_fb(1, 1, 8'd2, 8'h02, 32'd2, 1'b1, 1'b0);
    step(); clear_in(); chk("age.c7", 32'(a_age_pulse), 32'd0);
    set_fb(1, 0, 8'd3, 8'h07, 32'd77, 1'b0, 1'b1);
    step(); clear_in();
    chk("age.c8", 32'(a_age_pulse), 32'd1);
    chk("age.c8_fail", 32'(a_fb_alloc_fail), 32'h1);
    set_lk(1, 0, 8'd1, 8'h01);
    set_lk(1, 1, 8'd2, 8'h02);
    step(); clear_in();
    chk("age.A_hit", 32'(a_pred_hit[0]), 32'd1);
    chk("age.A_u", 32'(a_pred_useful[1:0]), 32'd1);
    chk("age.B_hit", 32'(a_pred_hit[1]), 32'd1);
    chk("age.B_u", 32'(a_pred_useful[3:2]), 32'd1);
    set_lk(1, 0, 8'd3, 8'h03);
    step(); clear_in();
    chk("age.R_hit", 32'(a_pred_hit[0]), 32'd1);
    chk("age.R_u", 32'(a_pred_useful[1:0]), 32'd0);
    chk("age.R_val", a_pred_value[31:0], 32'd3);

    // Asynchronous reset in the middle of active lookups.
    set_lk(0, 0, 8'd9, 8'h22);
    set_lk(1, 0, 8'd1, 8'h01);
    step();
    chk("ar.pre_valid", 32'(pred_valid[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar.pred_valid", 32'(pred_valid), 32'd0);
    chk("ar.pred_hit", 32'(pred_hit), 32'd0);
    chk("ar.pred_value", pred_value[31:0], 32'd0);
    chk("ar.pred_useful", 32'(pred_useful), 32'd0);
    chk("ar.a_pred_valid", 32'(a_pred_valid), 32'd0);
    chk("ar.a_pred_conf", 32'(a_pred_conf), 32'd0);
    #2 rst_n = 1'b1;
    clear_in();
    set_lk(0, 0, 8'd9, 8'h22);
    step(); clear_in();
    chk_pred("ar.cleared", 0, 1'b0, 32'd0, 3'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
